// File: rtl/global_buffer_mb.sv
// rtl/global_buffer_mb.sv - multi-bank global buffer, one masked write port, round-robin arbitrated read ports
module global_buffer_mb #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 128,
    parameter int NUM_BANKS = 4,
    parameter int BANK_AW   = 12,
    parameter int NUM_RD    = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [DATA_W/8-1:0]        wr_be,
    input  logic [NUM_RD-1:0]          rd_req,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD-1:0]          rd_gnt,
    output logic [NUM_RD-1:0]          rd_valid,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [31:0]                conflict_cnt
);

    localparam int SEL_W  = $clog2(NUM_BANKS);
    localparam int NBYTES = DATA_W / 8;
    localparam int DEPTH  = 1 << BANK_AW;
    localparam int PTR_W  = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;

    logic [DATA_W-1:0]  mem [NUM_BANKS][DEPTH];
    logic [DATA_W-1:0]  bank_rdata [NUM_BANKS];

    logic [SEL_W-1:0]   wr_bank;
    logic [BANK_AW-1:0] wr_word;
    logic [SEL_W-1:0]   rd_bank [NUM_RD];
    logic [BANK_AW-1:0] rd_word [NUM_RD];

    logic [PTR_W-1:0]   ptr_q [NUM_BANKS];
    logic [PTR_W-1:0]   ptr_d [NUM_BANKS];
    logic [NUM_RD-1:0]  gnt;
    logic [NUM_BANKS-1:0] bank_en;
    logic [BANK_AW-1:0] bank_word [NUM_BANKS];

    logic [NUM_RD-1:0]  s1_valid_q, s1_valid_d;
    logic [SEL_W-1:0]   s1_sel_q [NUM_RD];
    logic [SEL_W-1:0]   s1_sel_d [NUM_RD];
    logic [NUM_RD-1:0]  rd_valid_q, rd_valid_d;
    logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
    logic [31:0]        conflict_q, conflict_d;

    // Middle address bits alias by design and are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{wr_addr, rd_addr};

    assign wr_bank = wr_addr[ADDR_W-1 -: SEL_W];
    assign wr_word = wr_addr[BANK_AW-1:0];

    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            rd_bank[p] = rd_addr[p*ADDR_W + ADDR_W - 1 -: SEL_W];
            rd_word[p] = rd_addr[p*ADDR_W +: BANK_AW];
        end
    end

    // Per bank, grant the eligible port with the smallest cyclic distance from the pointer.
    always_comb begin
        gnt     = '0;
        bank_en = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            ptr_d[b]     = ptr_q[b];
            bank_word[b] = '0;
        end
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int k = 0; k < NUM_RD; k++) begin
                for (int p = 0; p < NUM_RD; p++) begin
                    if (!bank_en[b] && rd_req[p] && (rd_bank[p] == SEL_W'(b)) &&
                        (((p + NUM_RD - int'(ptr_q[b])) % NUM_RD) == k)) begin
                        bank_en[b]   = 1'b1;
                        gnt[p]       = 1'b1;
                        bank_word[b] = rd_word[p];
                        ptr_d[b]     = PTR_W'((p + 1) % NUM_RD);
                    end
                end
            end
        end
    end

    assign rd_gnt = gnt;

    // Bank read registers sample before the same-edge write lands, giving read-first.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (bank_en[b]) begin
                bank_rdata[b] <= mem[b][bank_word[b]];
            end
        end
        if (wr_en) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (wr_be[i]) begin
                    mem[wr_bank][wr_word][i*8 +: 8] <= wr_data[i*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        s1_valid_d = gnt;
        rd_valid_d = s1_valid_q;
        rd_data_d  = rd_data_q;
        for (int p = 0; p < NUM_RD; p++) begin
            s1_sel_d[p] = rd_bank[p];
            if (s1_valid_q[p]) begin
                rd_data_d[p*DATA_W +: DATA_W] = bank_rdata[s1_sel_q[p]];
            end
        end
        conflict_d = conflict_q;
        if ((|(rd_req & ~gnt)) && (conflict_q != 32'hFFFF_FFFF)) begin
            conflict_d = conflict_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                ptr_q[b] <= '0;
            end
            for (int p = 0; p < NUM_RD; p++) begin
                s1_sel_q[p] <= '0;
            end
            s1_valid_q <= '0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
            conflict_q <= '0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                ptr_q[b] <= ptr_d[b];
            end
            for (int p = 0; p < NUM_RD; p++) begin
                s1_sel_q[p] <= s1_sel_d[p];
            end
            s1_valid_q <= s1_valid_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            conflict_q <= conflict_d;
        end
    end

    assign rd_valid     = rd_valid_q;
    assign rd_data      = rd_data_q;
    assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_global_buffer_mb.sv
// tb/tb_global_buffer_mb.sv - scoreboard bench for global_buffer_mb
module tb_global_buffer_mb;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         wr_en;
    logic [15:0]  wr_addr;
    logic [127:0] wr_data;
    logic [15:0]  wr_be;
    logic [1:0]   rd_req;
    logic [31:0]  rd_addr;
    logic [1:0]   rd_gnt;
    logic [1:0]   rd_valid;
    logic [255:0] rd_data;
    logic [31:0]  conflict_cnt;

    int errors = 0;
    int checks = 0;
    int exp_conf = 0;
    int run0 = 0;
    int last_run0 = 0;

    logic [127:0] model [int];
    logic [127:0] exp_q [2][$];

    always #5 clk = ~clk;

    global_buffer_mb dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_be        (wr_be),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_gnt       (rd_gnt),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .conflict_cnt (conflict_cnt)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int mkey(input logic [15:0] a);
        return int'(a[15:14]) * 4096 + int'(a[11:0]);
    endfunction

    function automatic logic [127:0] model_rd(input logic [15:0] a);
        int k;
        k = mkey(a);
        if (model.exists(k)) return model[k];
        return 'x;
    endfunction

    task automatic set_wr(input logic en, input logic [15:0] a, input logic [127:0] d, input logic [15:0] be);
        wr_en = en; wr_addr = a; wr_data = d; wr_be = be;
    endtask

    task automatic set_rd(input logic [1:0] req, input logic [15:0] a0, input logic [15:0] a1);
        rd_req = req; rd_addr = {a1, a0};
    endtask

    // Book-keeping at the falling edge, then advance to just after the next rising edge.
    task automatic tick(input logic chk, input logic [1:0] eg);
        logic [127:0] cur;
        int k;
        @(negedge clk);
        if (chk) check("gnt", rd_gnt, eg);
        check("gnt_without_req", rd_gnt & ~rd_req, 0);
        if (rst_n) begin
            for (int p = 0; p < 2; p++)
                if (rd_req[p] && rd_gnt[p]) exp_q[p].push_back(model_rd(rd_addr[p*16 +: 16]));
            if (|(rd_req & ~rd_gnt)) exp_conf++;
            if (wr_en) begin
                k = mkey(wr_addr);
                cur = model_rd(wr_addr);
                for (int i = 0; i < 16; i++)
                    if (wr_be[i]) cur[i*8 +: 8] = wr_data[i*8 +: 8];
                model[k] = cur;
            end
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            check("valid_in_reset", rd_valid, 0);
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (rd_valid[p]) begin
                    if (exp_q[p].size() == 0) check($sformatf("unexpected_valid_p%0d", p), 1, 0);
                    else check($sformatf("data_p%0d", p), rd_data[p*128 +: 128], exp_q[p].pop_front());
                end
            end
        end
        if (rd_valid[0]) run0++;
        else begin
            if (run0 != 0) last_run0 = run0;
            run0 = 0;
        end
    end

    initial begin
        rst_n = 1'b0;
        set_wr(0, 0, 0, 0);
        set_rd(0, 0, 0);
        @(posedge clk); #1;
        repeat (3) tick(0, 0);
        check("cnt_reset", conflict_cnt, 0);
        check("data_reset", rd_data, 0);
        check("valid_reset", rd_valid, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 256; i++) begin
            set_wr(1, 16'(i), {4{32'hC0DE_0000 + i}}, 16'hFFFF);
            tick(0, 0);
        end
        set_wr(1, 16'h0010, {16{8'hA5}}, 16'hFFFF); tick(0, 0);
        set_wr(1, 16'h4010, {16{8'h5A}}, 16'hFFFF); tick(0, 0);
        set_wr(1, 16'h8000, {4{$urandom}}, 16'hFFFF); tick(0, 0);
        set_wr(1, 16'h8001, {4{$urandom}}, 16'hFFFF); tick(0, 0);
        set_wr(1, 16'h0030, 128'h11, 16'hFFFF); tick(0, 0);
        set_wr(0, 0, 0, 0);

        // same-bank conflict with pointers fresh from reset
        set_rd(2'b11, 16'h8000, 16'h8001); tick(1, 2'b01);
        set_rd(2'b10, 16'h8000, 16'h8001); tick(1, 2'b10);
        set_rd(0, 0, 0); repeat (3) tick(0, 0);
        check("cnt_one_conflict", conflict_cnt, 1);
        set_rd(2'b11, 16'h8000, 16'h8001);
        tick(1, 2'b01); tick(1, 2'b10); tick(1, 2'b01);
        set_rd(0, 0, 0); repeat (3) tick(0, 0);
        check("cnt_alternate", conflict_cnt, exp_conf);

        // different banks, both granted
        set_rd(2'b11, 16'h0010, 16'h4010); tick(1, 2'b11);
        set_rd(0, 0, 0); repeat (3) tick(0, 0);
        check("cnt_no_conflict", conflict_cnt, exp_conf);

        // byte mask
        set_wr(1, 16'h0020, '1, 16'hFFFF); tick(0, 0);
        set_wr(1, 16'h0020, '0, 16'h00FF); tick(0, 0);
        set_wr(0, 0, 0, 0);
        check("mask_model", model_rd(16'h0020), {64'hFFFF_FFFF_FFFF_FFFF, 64'h0});
        set_rd(2'b01, 16'h0020, 0); tick(1, 2'b01);
        set_rd(0, 0, 0); repeat (3) tick(0, 0);

        // read-first collision
        set_wr(1, 16'h0030, 128'h22, 16'hFFFF);
        set_rd(2'b01, 16'h0030, 0); tick(1, 2'b01);
        set_wr(0, 0, 0, 0); tick(1, 2'b01);
        set_rd(0, 0, 0); repeat (3) tick(0, 0);

        // streaming 256 contiguous reads
        for (int i = 0; i < 256; i++) begin
            set_rd(2'b01, 16'(i), 0);
            tick(1, 2'b01);
        end
        set_rd(0, 0, 0); repeat (4) tick(0, 0);
        check("stream_run", last_run0, 256);

        // reset with reads in flight
        set_rd(2'b11, 16'h0010, 16'h4010); tick(1, 2'b11);
        rst_n = 1'b0;
        set_rd(0, 0, 0);
        #1;
        check("valid_at_reset", rd_valid, 0);
        exp_q[0].delete();
        exp_q[1].delete();
        exp_conf = 0;
        repeat (2) tick(0, 0);
        rst_n = 1'b1;
        repeat (4) tick(0, 0);
        check("cnt_after_reset", conflict_cnt, 0);
        set_rd(2'b11, 16'h8000, 16'h8001); tick(1, 2'b01);
        set_rd(0, 0, 0); repeat (3) tick(0, 0);
        check("cnt_final", conflict_cnt, exp_conf);
        check("pending_p0", exp_q[0].size(), 0);
        check("pending_p1", exp_q[1].size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
